// File: rtl/uart_sched_pkg.sv
// Shared types and sizing helpers for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_RELEASE,
        ST_ABORT
    } sched_state_t;

    function automatic int wd_width(input int timeout_cycles);
        return $clog2(timeout_cycles);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr, wrapping.
module rr_pick
    import uart_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick_oh,
    output logic [IDX_W-1:0] pick_idx,
    output logic             pick_any
);

    int unsigned      pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        pos      = 0;
        cand     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos  = (32'(ptr) + k) % N_REQ;
            cand = IDX_W'(pos);
            if (!pick_any && req_valid[cand]) begin
                pick_any      = 1'b1;
                pick_idx      = cand;
                pick_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Grants the shared UART transmitter to one source per message (round-robin) and
// streams its bytes over a four-phase tx_en/tx_over handshake with a stall watchdog.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [BYTE_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    tx_en,
    output logic [BYTE_W-1:0]       tx_data,
    input  logic                    tx_over,
    output logic                    busy,
    output logic                    msg_done,
    output logic                    timeout_err
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int WD_W  = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_REQ - 1);

    sched_state_t      state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  gidx;
    logic [WD_W-1:0]   wd_cnt;
    logic [BYTE_W-1:0] hold_data;
    logic              hold_last;

    logic [N_REQ-1:0]  pick_oh;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;

    logic              sel_valid;
    logic              sel_last;
    logic [BYTE_W-1:0] sel_data;
    logic              wd_hit;
    logic [IDX_W-1:0]  next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .pick_oh   (pick_oh),
        .pick_idx  (pick_idx),
        .pick_any  (pick_any)
    );

    // Grant is one-hot, so an AND-OR mux selects the owner's byte and flags.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sel_data = sel_data | (req_data[i*BYTE_W +: BYTE_W] & {BYTE_W{grant[i]}});
        end
    end

    assign sel_valid = |(req_valid & grant);
    assign sel_last  = |(req_last & grant);
    assign wd_hit    = (wd_cnt == WD_LIMIT);
    assign next_ptr  = (gidx == IDX_MAX) ? '0 : gidx + 1'b1;
    assign req_ready = (state == ST_FETCH) ? grant : '0;
    assign tx_data   = hold_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            gidx        <= '0;
            grant       <= '0;
            tx_en       <= 1'b0;
            hold_data   <= '0;
            hold_last   <= 1'b0;
            busy        <= 1'b0;
            msg_done    <= 1'b0;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            msg_done    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wd_cnt <= '0;
                    if (pick_any) begin
                        grant <= pick_oh;
                        gidx  <= pick_idx;
                        busy  <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (wd_hit) begin
                        timeout_err <= 1'b1;
                        wd_cnt      <= '0;
                        state       <= ST_ABORT;
                    end else if (sel_valid) begin
                        hold_data <= sel_data;
                        hold_last <= sel_last;
                        tx_en     <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= ST_SEND;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    if (wd_hit) begin
                        timeout_err <= 1'b1;
                        tx_en       <= 1'b0;
                        wd_cnt      <= '0;
                        state       <= ST_ABORT;
                    end else if (tx_over) begin
                        tx_en  <= 1'b0;
                        wd_cnt <= '0;
                        state  <= ST_RELEASE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (wd_hit) begin
                        timeout_err <= 1'b1;
                        wd_cnt      <= '0;
                        state       <= ST_ABORT;
                    end else if (!tx_over) begin
                        wd_cnt <= '0;
                        if (hold_last) begin
                            msg_done <= 1'b1;
                            ptr      <= next_ptr;
                            grant    <= '0;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ST_ABORT: begin
                    // Unwatched: only a stuck tx_over can hold us here.
                    wd_cnt <= '0;
                    if (!tx_over) begin
                        ptr   <= next_ptr;
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
